fir_tap_sequencer: RTL and testbench

- Control and datapath stage directly upstream of fakeMac16 in the audio filtering chain.
- Accepts one audio sample per handshake and stores it in a circular delay line, alongside a writable Q1.15 coefficient bank.
- Issues NTAPS consecutive multiply-accumulate operations to the MAC, chaining each partial sum back in as prevValue.
- Saturates the final 33-bit sum to one 16-bit output sample.

---
 rtl/fir_pkg.sv | 51 +++++
 rtl/fir_delay_line.sv | 49 ++++
 rtl/fir_tap_sequencer.sv | 152 +++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types, constants and the output saturation helper for
// the FIR tap sequencer.
//
// Contents:
//   NTAPS_DEF, DW_DEF, ACCW_DEF - default tap count, sample width and
//                                 accumulator width
//   FRAC_BITS                   - fractional bits of the Q1.15 coefficients
//   sample_t, acc_t             - signed sample / accumulator types
//   fir_state_t                 - sequencer states IDLE, RUN, DONE
//   sat16()                     - arithmetic shift by FRAC_BITS, then clamp
//                                 to the signed DW-bit range
package fir_pkg;

    localparam int NTAPS_DEF = 16;
    localparam int DW_DEF    = 16;
    localparam int ACCW_DEF  = 33;
    localparam int FRAC_BITS = 15;

    typedef logic signed [DW_DEF-1:0]   sample_t;
    typedef logic signed [ACCW_DEF-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    // The argument is one bit wider than the accumulator so that a rounding
    // bias can be added without wrapping before the shift.
    function automatic sample_t sat16(input logic signed [ACCW_DEF:0] v);
        logic signed [ACCW_DEF:0] s;
        logic signed [ACCW_DEF:0] max_v;
        logic signed [ACCW_DEF:0] min_v;
        sample_t                  r;
        s = v >>> FRAC_BITS;
        // max_v = +(2^(DW-1) - 1), min_v = -2^(DW-1), built width-generically
        max_v = '0;
        max_v[DW_DEF-2:0] = '1;
        min_v = '1;
        min_v[DW_DEF-2:0] = '0;
        if (s > max_v) begin
            r = max_v[DW_DEF-1:0];
        end else if (s < min_v) begin
            r = min_v[DW_DEF-1:0];
        end else begin
            r = s[DW_DEF-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: circular sample buffer for the FIR tap sequencer.
//
// A write stores wr_data at the write pointer and advances it (mod NTAPS).
// The read port is combinational and returns the sample written k writes
// ago, i.e. x[n-k] where x[n] is the most recent sample:
//   rd_data = mem[(wp - 1 - rd_k) mod NTAPS]
// rst_i synchronously clears the whole buffer and the write pointer.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   wr_en_i  in   write strobe (one sample per strobe)
//   wr_data  in   DW-bit sample to store
//   rd_k     in   tap offset k
//   rd_data  out  sample x[n-k]
module fir_delay_line #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_k,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [NTAPS];
    logic [AW-1:0] wp;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem[wp] <= wr_data;
            wp      <= wp + AW'(1);
        end
    end

    // NTAPS is a power of two, so AW-bit arithmetic wraps modulo NTAPS.
    assign rd_addr = wp - AW'(1) - rd_k;
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: drives an external 1-cycle-latency multiply-accumulate
// unit through NTAPS taps per input sample and saturates the final sum.
//
// Build option: define FIR_ROUND_EN to round half-up before saturation;
// otherwise the sum is truncated (arithmetic shift right by 15).
//
// Handshake (sample_valid_i / sample_ready_o): a sample is accepted on a
// rising clock edge where both are 1. Ready is 1 only in IDLE; the upstream
// block holds valid and data stable until the accept edge, so nothing is
// lost while the sequencer is busy. out_valid_o is a single-cycle pulse
// with no back-pressure.
//
// Sequence per accepted sample (E0 = accepting edge):
//   RUN  for NTAPS cycles, k = 0..NTAPS-1: mac_clk_en_o = 1,
//        mac_a_o = x[n-k], mac_b_o = coef[k],
//        mac_prev_o = 0 for k = 0, else mac_result_i (combinational chain)
//   DONE for one cycle: mac_result_i holds the full sum; it is saturated
//        into out_sample_o on the edge closing DONE
//   out_valid_o pulses in the cycle after that, NTAPS+2 edges after E0.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   sample_valid_i/sample_i input sample handshake and data
//   sample_ready_o          1 while IDLE
//   coef_we_i/addr/data     coefficient write port, accepted in any state
//   mac_clk_en_o            MAC clock enable
//   mac_a_o, mac_b_o        MAC multiplicands (sample, coefficient)
//   mac_prev_o              MAC addend (previous partial sum)
//   mac_result_i            MAC registered result
//   out_valid_o/out_sample_o filtered output sample
//   state_o                 current sequencer state (fir_state_t encoding)
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACCW  = ACCW_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sample_valid_i,
    input  logic [DW-1:0]            sample_i,
    output logic                     sample_ready_o,
    input  logic                     coef_we_i,
    input  logic [$clog2(NTAPS)-1:0] coef_addr_i,
    input  logic [DW-1:0]            coef_data_i,
    output logic                     mac_clk_en_o,
    output logic [DW-1:0]            mac_a_o,
    output logic [DW-1:0]            mac_b_o,
    output logic [ACCW-1:0]          mac_prev_o,
    input  logic [ACCW-1:0]          mac_result_i,
    output logic                     out_valid_o,
    output logic [DW-1:0]            out_sample_o,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(NTAPS);

    fir_state_t      state;
    logic [AW-1:0]   k;
    logic [DW-1:0]   coef [NTAPS];
    logic            out_pend;
    logic            accept;
    logic            in_run;
    logic [DW-1:0]   tap_sample;
    logic [ACCW:0]   acc_ext;
    logic [ACCW:0]   acc_adj;

`ifdef FIR_ROUND_EN
    // 2^(FRAC_BITS-1): half an LSB of the output, added before the shift.
    localparam logic [ACCW:0] ROUND_BIAS =
        {{(ACCW - FRAC_BITS + 1){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
`endif

    assign accept = sample_valid_i && sample_ready_o;
    assign in_run = (state == RUN);

    fir_delay_line #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .AW    (AW)
    ) u_delay_line (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en_i (accept),
        .wr_data (sample_i),
        .rd_k    (k),
        .rd_data (tap_sample)
    );

    // Sign-extend by one bit so the optional bias cannot wrap the sum.
    assign acc_ext = {mac_result_i[ACCW-1], mac_result_i};
`ifdef FIR_ROUND_EN
    assign acc_adj = acc_ext + ROUND_BIAS;
`else
    assign acc_adj = acc_ext;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            k            <= '0;
            out_pend     <= 1'b0;
            out_valid_o  <= 1'b0;
            out_sample_o <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
            end
        end else begin
            out_valid_o <= out_pend;
            out_pend    <= 1'b0;

            // Committed at the edge: a tap reading this index in the same
            // cycle still sees the old coefficient.
            if (coef_we_i) begin
                coef[coef_addr_i] <= coef_data_i;
            end

            case (state)
                IDLE: begin
                    if (sample_valid_i) begin
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    k <= k + AW'(1);
                    if (k == AW'(NTAPS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    out_sample_o <= sat16(acc_adj);
                    out_pend     <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sample_ready_o = (state == IDLE);
    assign mac_clk_en_o   = in_run;
    assign mac_a_o        = in_run ? tap_sample : '0;
    assign mac_b_o        = in_run ? coef[k] : '0;
    // Tap 0 starts a fresh sum; later taps chain the MAC's previous result.
    assign mac_prev_o     = (in_run && (k != '0)) ? mac_result_i : '0;
    assign state_o        = state;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

    logic        clk;
    logic        rst_i;
    logic        sample_valid_i;
    logic [15:0] sample_i;
    logic        sample_ready_o;
    logic        coef_we_i;
    logic [3:0]  coef_addr_i;
    logic [15:0] coef_data_i;
    logic        mac_clk_en_o;
    logic [15:0] mac_a_o;
    logic [15:0] mac_b_o;
    logic [32:0] mac_prev_o;
    logic [32:0] mac_result_i;
    logic        out_valid_o;
    logic [15:0] out_sample_o;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    int last_acc = 0;

    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic [15:0] coef_m [16];
    logic [15:0] hist_m [16];

    fir_tap_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .sample_ready_o (sample_ready_o),
        .coef_we_i      (coef_we_i),
        .coef_addr_i    (coef_addr_i),
        .coef_data_i    (coef_data_i),
        .mac_clk_en_o   (mac_clk_en_o),
        .mac_a_o        (mac_a_o),
        .mac_b_o        (mac_b_o),
        .mac_prev_o     (mac_prev_o),
        .mac_result_i   (mac_result_i),
        .out_valid_o    (out_valid_o),
        .out_sample_o   (out_sample_o),
        .state_o        (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // External MAC: result <= prev + a*b when enabled, 1-cycle latency.
    always @(posedge clk) begin
        if (rst_i) begin
            mac_result_i <= '0;
        end else if (mac_clk_en_o) begin
            mac_result_i <= 33'($signed(mac_prev_o) + $signed(mac_a_o) * $signed(mac_b_o));
        end
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_i = 1'b1;
        sample_valid_i = 1'b0;
        coef_we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            coef_m[i] = '0;
            hist_m[i] = '0;
        end
        acc_q.delete();
    endtask

    task automatic write_coef(input int idx, input logic [15:0] v);
        @(negedge clk);
        coef_we_i   = 1'b1;
        coef_addr_i = 4'(idx);
        coef_data_i = v;
        @(negedge clk);
        coef_we_i = 1'b0;
        coef_m[idx] = v;
    endtask

    task automatic send(input logic [15:0] v, input bit hold);
        int n;
        n = 0;
        sample_i = v;
        sample_valid_i = 1'b1;
        while (!sample_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", sample_ready_o, 1);
        @(posedge clk);
        #1;
        for (int i = 15; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = v;
        acc_q.push_back(cyc);
        last_acc = cyc;
        if (!hold) sample_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq("drain", exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int run = 0;
    always @(negedge clk) begin
        if (rst_i) begin
            run = 0;
        end else begin
            if (mac_clk_en_o) begin
                if (run < 16) begin
                    check_eq("mac_b", mac_b_o, coef_m[run]);
                    check_eq("mac_a", mac_a_o, hist_m[run]);
                end
                if (run == 0) check_eq("mac_prev0", mac_prev_o, 0);
                else          check_eq("mac_prev", mac_prev_o, mac_result_i);
                run++;
            end else if (run != 0) begin
                check_eq("clk_en_run", run, 16);
                run = 0;
            end
            if (out_valid_o) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", out_valid_o, 0);
                end else begin
                    check_eq("out_sample", out_sample_o, exp_q.pop_front());
                    if (acc_q.size() > 0) check_eq("latency", cyc - acc_q.pop_front(), 18);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int saved_cnt;
    logic [15:0] ev;

    initial begin
        sample_valid_i = 1'b0;
        sample_i = '0;
        coef_we_i = 1'b0;
        coef_addr_i = '0;
        coef_data_i = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        check_eq("rst_ready", sample_ready_o, 1);
        check_eq("rst_clk_en", mac_clk_en_o, 0);
        check_eq("rst_mac_a", mac_a_o, 0);
        check_eq("rst_mac_b", mac_b_o, 0);
        check_eq("rst_mac_prev", mac_prev_o, 0);
        check_eq("rst_out_valid", out_valid_o, 0);
        check_eq("rst_out_sample", out_sample_o, 0);
        repeat (4) begin
            @(negedge clk);
            check_eq("idle_clk_en", mac_clk_en_o, 0);
        end

        // Impulse response, coef[k] = 0x0400*(k+1)
        for (int k = 0; k < 16; k++) write_coef(k, 16'((k + 1) * 1024));
        for (int k = 0; k < 16; k++) begin
`ifdef FIR_ROUND_EN
            ev = 16'((k + 1) * 1024);
`else
            ev = 16'((k + 1) * 1024 - 1);
`endif
            exp_q.push_back(ev);
            send((k == 0) ? 16'h7FFF : 16'h0000, 1'b0);
        end
        wait_drain();

        // Positive saturation
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, 16'h7FFF);
        exp_q.push_back(16'h7FFE);
        repeat (3) exp_q.push_back(16'h7FFF);
        repeat (4) send(16'h7FFF, 1'b0);
        wait_drain();

        // Negative saturation
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, 16'h7FFF);
`ifdef FIR_ROUND_EN
        exp_q.push_back(16'h8002);
`else
        exp_q.push_back(16'h8001);
`endif
        repeat (3) exp_q.push_back(16'h8000);
        repeat (4) send(16'h8001, 1'b0);
        wait_drain();

        // Handshake: valid held high, incrementing data, c[0] = 0.5
        do_reset();
        write_coef(0, 16'h4000);
        for (int i = 0; i < 4; i++) begin
            int prev;
            prev = last_acc;
            exp_q.push_back(16'(16'h0100 + i));
            send(16'(16'h0200 + 2 * i), (i < 3));
            if (i > 0) check_eq("accept_period", last_acc - prev, 18);
            if (i < 3) begin
                repeat (17) begin
                    @(negedge clk);
                    check_eq("busy_ready", sample_ready_o, 0);
                end
            end
        end
        sample_valid_i = 1'b0;
        wait_drain();

        // Reset during RUN at k=5
        do_reset();
        for (int k = 0; k < 16; k++) write_coef(k, 16'((k + 1) * 1024));
        send(16'h7FFF, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("midrun_clk_en", mac_clk_en_o, 1);
        saved_cnt = out_cnt;
        do_reset();
        repeat (25) @(negedge clk);
        check_eq("abort_no_out", out_cnt - saved_cnt, 0);
        check_eq("abort_ready", sample_ready_o, 1);
        for (int k = 0; k < 16; k++) write_coef(k, 16'((k + 1) * 1024));
        for (int k = 0; k < 16; k++) begin
`ifdef FIR_ROUND_EN
            ev = 16'((k + 1) * 1024);
`else
            ev = 16'((k + 1) * 1024 - 1);
`endif
            exp_q.push_back(ev);
            send((k == 0) ? 16'h7FFF : 16'h0000, 1'b0);
        end
        wait_drain();

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
